// File: rtl/des_encrypt_iter.sv
// Iterative DES encryptor: one Feistel round per clock, 18-cycle block turnaround.
// Optional key-byte odd-parity rejection is enabled by defining DES_KEY_PARITY_EN.
module des_encrypt_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] data_in,
  input  logic [63:0] key_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] data_out,
  output logic        key_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Tables use FIPS 46-3 numbering: bit 1 is the MSB of the vector.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // S1..S8 flattened as box*64 + row*16 + col.
  localparam int SBOX_T [512] = '{
    14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
    0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
    4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
    15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
    15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
    3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
    0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
    13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
    10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
    13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
    1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
    7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
    13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
    10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
    3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
    2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
    14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
    4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
    11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
    12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
    10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
    9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
    4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
    4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
    13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
    1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
    6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
    13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
    1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
    7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
    2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11
  };

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
    return y;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
    return y;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] x, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s;
    logic [31:0] y;
    logic [5:0]  six;
    int          v;
    for (int i = 0; i < 48; i++) e[6'(47 - i)] = x[5'(32 - E_T[i])];
    e = e ^ k;
    for (int b = 0; b < 8; b++) begin
      six = e[6'(47 - 6 * b) -: 6];
      v = SBOX_T[9'(b * 64 + int'({six[5], six[0]}) * 16 + int'(six[4:1]))];
      s[5'(31 - 4 * b) -: 4] = v[3:0];
    end
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = s[5'(32 - P_T[i])];
    return y;
  endfunction

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] l_q;
  logic [31:0] r_q;
  logic [27:0] c_q;
  logic [27:0] d_q;
  logic [27:0] c_rot;
  logic [27:0] d_rot;
  logic [31:0] f_out;
  logic [63:0] ip_in;
  logic [55:0] pc1_key;
  logic        one_shift;
  logic        key_par_ok;
  logic        par_reject;

  assign in_ready = (state == IDLE);

  always_comb begin
    one_shift = (cnt == 4'd0) || (cnt == 4'd1) || (cnt == 4'd8) || (cnt == 4'd15);
    c_rot = one_shift ? {c_q[26:0], c_q[27]} : {c_q[25:0], c_q[27:26]};
    d_rot = one_shift ? {d_q[26:0], d_q[27]} : {d_q[25:0], d_q[27:26]};
    f_out = feistel(r_q, perm_pc2({c_rot, d_rot}));
    ip_in = perm_ip(data_in);
    pc1_key = perm_pc1(key_in);
  end

`ifdef DES_KEY_PARITY_EN
  logic key_err_q;

  always_comb begin
    key_par_ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      if (!(^key_in[6'(8 * b) +: 8])) key_par_ok = 1'b0;
    end
  end

  assign par_reject = in_ready && in_valid && !key_par_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) key_err_q <= 1'b0;
    else     key_err_q <= par_reject;
  end

  assign key_err = key_err_q;
`else
  assign key_par_ok = 1'b1;
  assign par_reject = 1'b0;
  assign key_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      l_q       <= 32'd0;
      r_q       <= 32'd0;
      c_q       <= 28'd0;
      d_q       <= 28'd0;
      data_out  <= 64'd0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && key_par_ok) begin
            l_q   <= ip_in[63:32];
            r_q   <= ip_in[31:0];
            c_q   <= pc1_key[55:28];
            d_q   <= pc1_key[27:0];
            cnt   <= 4'd0;
            state <= ROUND;
          end
        end
        ROUND: begin
          c_q <= c_rot;
          d_q <= d_rot;
          l_q <= r_q;
          r_q <= l_q ^ f_out;
          cnt <= cnt + 4'd1;
          // Final swap: preoutput is R16 || L16.
          if (cnt == 4'd15) begin
            data_out  <= perm_fp({l_q ^ f_out, r_q});
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_encrypt_iter.sv
// Directed-vector bench for des_encrypt_iter: known-answer table plus stall, reset-abort,
// back-to-back and key-parity sequences.
module tb_des_encrypt_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] data_in;
  logic [63:0] key_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] data_out;
  logic        key_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [63:0] key;
    logic [63:0] pt;
    logic [63:0] ct;
    logic        par_ok;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  des_encrypt_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .key_in    (key_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .key_err   (key_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 40);
    chk({name, " latency"}, 64'(n), 64'd16);
  endtask

  task automatic start(input string name, input logic [63:0] key, input logic [63:0] pt);
    int g;
    g = 0;
    while (!in_ready && g < 50) begin
      tick();
      g++;
    end
    if (!in_ready) chk1({name, " in_ready wait"}, in_ready, 1'b1);
    in_valid = 1'b1;
    key_in   = key;
    data_in  = pt;
    tick();
    in_valid = 1'b0;
    key_in   = ~key;
    data_in  = ~pt;
    chk1({name, " accepted"}, in_ready, 1'b0);
  endtask

  task automatic run_block(input string name, input logic [63:0] key, input logic [63:0] pt,
                           input logic [63:0] ct);
    out_ready = 1'b1;
    start(name, key, pt);
    wait_out(name);
    chk({name, " data_out"}, data_out, ct);
    tick();
    chk1({name, " out_valid drop"}, out_valid, 1'b0);
    chk({name, " data_out retained"}, data_out, ct);
    chk1({name, " in_ready after"}, in_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    vecs[0] = '{"fips_std", 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405, 1'b1};
    vecs[1] = '{"weak_key", 64'h0101010101010101, 64'h0000000000000000, 64'h8CA64DE9C1B123A7, 1'b1};
    vecs[2] = '{"zero_ct",  64'h0E329232EA6D0D73, 64'h8787878787878787, 64'h0000000000000000, 1'b1};
    vecs[3] = '{"now_is_t", 64'h0123456789ABCDEF, 64'h4E6F772069732074, 64'h3FA40E8A984D4815, 1'b1};
    vecs[4] = '{"compl",    64'hECCBA8866443200E, 64'hFEDCBA9876543210, 64'h7A17ECABF0F54BFA, 1'b1};
    vecs[5] = '{"key_zero", 64'h0000000000000000, 64'h0000000000000000, 64'h8CA64DE9C1B123A7, 1'b0};
    vecs[6] = '{"all_ones", 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h7359B2163E4EDC58, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    data_in   = 64'd0;
    key_in    = 64'd0;
    #1;
    chk1("reset in_ready", in_ready, 1'b1);
    chk1("reset out_valid", out_valid, 1'b0);
    chk("reset data_out", data_out, 64'd0);
    chk1("reset key_err", key_err, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
`ifdef DES_KEY_PARITY_EN
      if (vecs[i].par_ok)
        run_block(vecs[i].name, vecs[i].key, vecs[i].pt, vecs[i].ct);
`else
      run_block(vecs[i].name, vecs[i].key, vecs[i].pt, vecs[i].ct);
`endif
    end

    // Output stall: DONE holds while new offers are ignored.
    out_ready = 1'b0;
    start("stall", vecs[3].key, vecs[3].pt);
    wait_out("stall");
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      data_in  = {$urandom, $urandom};
      key_in   = vecs[0].key;
      tick();
      chk1("stall out_valid", out_valid, 1'b1);
      chk("stall data_out", data_out, vecs[3].ct);
      chk1("stall in_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk1("stall release out_valid", out_valid, 1'b0);
    chk1("stall release in_ready", in_ready, 1'b1);
    tick();
    chk1("stall no late accept", in_ready, 1'b1);

    // Reset in round 8 aborts the block; offers during reset are ignored.
    start("abort", vecs[1].key, vecs[1].pt);
    repeat (7) tick();
    rst      = 1'b1;
    in_valid = 1'b1;
    key_in   = vecs[0].key;
    data_in  = vecs[0].pt;
    #1;
    chk1("abort in_ready async", in_ready, 1'b1);
    chk1("abort out_valid async", out_valid, 1'b0);
    tick();
    tick();
    chk1("abort in_ready held", in_ready, 1'b1);
    rst      = 1'b0;
    in_valid = 1'b0;
    bad = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (out_valid || !in_ready) bad++;
    end
    chk("abort no output", 64'(bad), 64'd0);
    run_block("after_abort", vecs[0].key, vecs[0].pt, vecs[0].ct);

    // Back-to-back with in_valid held high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    key_in    = vecs[0].key;
    data_in   = vecs[0].pt;
    tick();
    chk1("b2b first accept", in_ready, 1'b0);
    key_in  = vecs[3].key;
    data_in = vecs[3].pt;
    wait_out("b2b first");
    chk("b2b first data", data_out, vecs[0].ct);
    tick();
    chk1("b2b handshake out_valid", out_valid, 1'b0);
    chk1("b2b handshake in_ready", in_ready, 1'b1);
    tick();
    chk1("b2b second accept", in_ready, 1'b0);
    in_valid = 1'b0;
    key_in   = 64'd0;
    data_in  = 64'd0;
    wait_out("b2b second");
    chk("b2b second data", data_out, vecs[3].ct);
    tick();
    chk1("b2b second drop", out_valid, 1'b0);

`ifdef DES_KEY_PARITY_EN
    in_valid = 1'b1;
    key_in   = 64'h123457799BBCDFF1;
    data_in  = 64'h0123456789ABCDEF;
    tick();
    chk1("parity key_err", key_err, 1'b1);
    chk1("parity in_ready", in_ready, 1'b1);
    in_valid = 1'b0;
    tick();
    chk1("parity key_err pulse end", key_err, 1'b0);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (out_valid || !in_ready || key_err) bad++;
    end
    chk("parity no start", 64'(bad), 64'd0);
`else
    in_valid = 1'b1;
    key_in   = 64'h123457799BBCDFF1;
    data_in  = 64'h0123456789ABCDEF;
    tick();
    chk1("no parity key_err", key_err, 1'b0);
    chk1("no parity accepted", in_ready, 1'b0);
    in_valid = 1'b0;
    wait_out("no parity");
    tick();
`endif

    rst = 1'b1;
    #1;
    chk("final reset data_out", data_out, 64'd0);
    chk1("final reset in_ready", in_ready, 1'b1);
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_encrypt_iter.md
DES_ENCRYPT_ITER -- requirements
Module: des_encrypt_iter

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, which indicates that a plaintext block and key are offered.
REQ-004 SHALL have port in_ready, output, 1, which is high only in IDLE.
REQ-005 SHALL have port data_in, input, 64, the plaintext block; bit 63 is FIPS 46-3 bit 1.
REQ-006 SHALL have port key_in, input, 64, the key including parity bits 8,16,...,64.
REQ-007 SHALL have port out_valid, output, 1, which indicates that data_out holds a ciphertext.
REQ-008 SHALL have port out_ready, input, 1, the downstream accept.
REQ-009 SHALL have port data_out, output, 64, the ciphertext.
REQ-010 SHALL have port key_err, output, 1, a one-cycle key-parity reject pulse.

Function
REQ-011 SHALL implement DES encryption per FIPS 46-3: IP, 16 Feistel rounds (E, S1-S8, P), PC-1/PC-2 key schedule, left rotations {1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1}, and final swap plus FP.
REQ-012 SHALL use a three-state FSM: IDLE, ROUND, DONE.
REQ-013 SHALL, in IDLE with in_valid high, accept on the edge: L/R <= IP(data_in) halves, C/D <= PC-1(key_in), round counter <= 0, and go to ROUND.
REQ-014 SHALL, in ROUND, perform exactly one round per cycle: rotate C/D, then L <= R and R <= L ^ f(R, PC-2(C,D)); the counter increments 0..15.
REQ-015 SHALL, on the edge completing round 16, register data_out <= FP({R16,L16}), set out_valid, and enter DONE.
REQ-016 SHALL deliver out_valid exactly 16 rising edges after the accepting edge.
REQ-017 SHALL hold out_valid and data_out stable in DONE until out_valid and out_ready are both high, then return to IDLE on that edge.
REQ-018 SHALL give throughput of one block per 18 cycles minimum, since in_ready is low in ROUND and DONE.
REQ-019 SHALL ignore in_valid, data_in and key_in outside IDLE; changing them after acceptance SHALL NOT affect the result.
REQ-020 SHALL retain data_out after the output handshake until the next result overwrites it; out_valid drops on the handshake edge.
REQ-021 SHALL compute each round from registered state only; no combinational path from in_valid or out_ready to data_out.

Reset
REQ-022 SHALL, on rst high, immediately force the FSM to IDLE and clear out_valid, key_err, data_out, L, R, C, D and the counter to 0; in_ready then reads 1.
REQ-023 SHALL abort any in-flight block on reset mid-ROUND or mid-DONE, with no out_valid produced for it.
REQ-024 SHALL accept no block while rst is high, including in the first cycle after deassertion if rst is still sampled high.

Configuration
REQ-025 SHALL support the macro DES_KEY_PARITY_EN.
REQ-026 SHALL, when DES_KEY_PARITY_EN is defined, check each key byte for odd parity during an IDLE handshake; on any failure the block is not started, stays in IDLE, and key_err pulses high for exactly one cycle.
REQ-027 SHALL, when DES_KEY_PARITY_EN is undefined, ignore the parity bits and tie key_err to 0.

Verification
REQ-028 SHALL pass this scenario: key 133457799BBCDFF1, data_in 0123456789ABCDEF, out_ready=1 -> data_out 85E813540F0AB405 with out_valid 16 edges after acceptance.
REQ-029 SHALL pass this scenario: key 0101010101010101, data_in 0000000000000000 -> data_out 8CA64DE9C1B123A7.
REQ-030 SHALL pass this scenario: out_ready held 0 for 10 cycles after out_valid -> data_out and out_valid stable, in_ready 0; a new in_valid offered meanwhile is not accepted.
REQ-031 SHALL pass this scenario: rst pulsed at round 8 -> out_valid never rises for that block; the next accepted block (REQ-028 vector) yields the correct ciphertext.
REQ-032 SHALL pass this scenario: with DES_KEY_PARITY_EN, key 123457799BBCDFF1 -> key_err one-cycle pulse, in_ready stays 1, no out_valid; without the macro, key 0000000000000000 and data_in 0 -> 8CA64DE9C1B123A7.
REQ-033 SHALL pass this scenario: back-to-back blocks with out_ready=1 -> second acceptance occurs exactly one cycle after the first output handshake.
